// File: rtl/csr_int_unit.sv
// csr_int_unit: owns ECFG.LIE, ESTAT.IS, TCFG/TVAL/TICLR, runs the constant timer and raises int_req to WB.
// Optional macro IPI_EN adds ipi_int_in (into ESTAT.IS[12]) and makes ECFG.LIE[12] writable.
module csr_int_unit #(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_we,
  input  logic [13:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] csr_wmask,
  output logic [31:0] csr_rdata,
  input  logic [7:0]  hw_int_in,
`ifdef IPI_EN
  input  logic        ipi_int_in,
`endif
  input  logic        crmd_ie,
  input  logic        int_ack,
  input  logic        ertn_flush,
  output logic        int_req,
  output logic [1:0]  csr_ecfg_lie_soft,
  output logic        timer_int
);
  localparam logic [13:0] ADDR_ECFG  = 14'h004;
  localparam logic [13:0] ADDR_ESTAT = 14'h005;
  localparam logic [13:0] ADDR_TCFG  = 14'h041;
  localparam logic [13:0] ADDR_TVAL  = 14'h042;
  localparam logic [13:0] ADDR_TICLR = 14'h044;
`ifdef IPI_EN
  localparam logic [12:0] LIE_WMASK = 13'h1BFF;
`else
  localparam logic [12:0] LIE_WMASK = 13'h0BFF;
`endif

  typedef enum logic [1:0] {T_OFF, T_RUN, T_DONE} tstate_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rstate_e;

  logic [12:0]        lie_q, lie_d;
  logic [1:0]         is_sw_q, is_sw_d;
  logic [7:0]         is_hw_q, is_hw_d;
  logic               ti_q, ti_d;
  logic               is_ipi;
  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  tstate_e            tstate_q, tstate_d;
  rstate_e            rstate_q, rstate_d;

  logic               wr_ecfg, wr_estat, wr_tcfg, ticlr_clr, ti_set, pending;
  logic [12:0]        lie_new, is_vec;
  logic [1:0]         is_sw_new;
  logic [TIMER_W-1:0] tcfg_new;

  assign wr_ecfg   = csr_we && (csr_addr == ADDR_ECFG);
  assign wr_estat  = csr_we && (csr_addr == ADDR_ESTAT);
  assign wr_tcfg   = csr_we && (csr_addr == ADDR_TCFG);
  assign ticlr_clr = csr_we && (csr_addr == ADDR_TICLR) && csr_wdata[0] && csr_wmask[0];

  assign lie_new   = (csr_wdata[12:0] & csr_wmask[12:0]) | (lie_q & ~csr_wmask[12:0]);
  assign is_sw_new = (csr_wdata[1:0] & csr_wmask[1:0]) | (is_sw_q & ~csr_wmask[1:0]);
  assign tcfg_new  = (csr_wdata[TIMER_W-1:0] & csr_wmask[TIMER_W-1:0]) |
                     (tcfg_q & ~csr_wmask[TIMER_W-1:0]);

`ifdef IPI_EN
  logic is_ipi_q, is_ipi_d;
  assign is_ipi_d = ipi_int_in;
  always_ff @(posedge clk) begin
    if (reset) is_ipi_q <= 1'b0;
    else       is_ipi_q <= is_ipi_d;
  end
  assign is_ipi = is_ipi_q;
`else
  assign is_ipi = 1'b0;
`endif

  assign is_vec  = {is_ipi, ti_q, 1'b0, is_hw_q, is_sw_q};
  assign pending = (|(is_vec & lie_q)) & crmd_ie;

  // CSR field updates and constant timer; a TCFG write pre-empts expiry in the same cycle
  always_comb begin
    lie_d    = lie_q;
    is_sw_d  = is_sw_q;
    is_hw_d  = hw_int_in;
    tcfg_d   = tcfg_q;
    tval_d   = tval_q;
    tstate_d = tstate_q;
    ti_set   = 1'b0;
    if (wr_ecfg)  lie_d   = lie_new & LIE_WMASK;
    if (wr_estat) is_sw_d = is_sw_new;
    if (wr_tcfg) begin
      tcfg_d = tcfg_new;
      if (tcfg_new[0]) begin
        tval_d   = {tcfg_new[TIMER_W-1:2], 2'b00};
        tstate_d = T_RUN;
      end else begin
        tstate_d = T_OFF;
      end
    end else if (tstate_q == T_RUN) begin
      if (tval_q == '0) begin
        ti_set = 1'b1;
        if (tcfg_q[1]) tval_d   = {tcfg_q[TIMER_W-1:2], 2'b00};
        else           tstate_d = T_DONE;
      end else begin
        tval_d = tval_q - TIMER_W'(1);
      end
    end
    ti_d = ti_set | (ti_q & ~ticlr_clr);
  end

  // Request handshake: an ack taken together with a pending drop still goes to WAIT
  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE: if (pending) rstate_d = R_REQ;
      R_REQ: begin
        if (int_ack)       rstate_d = R_WAIT;
        else if (!pending) rstate_d = R_IDLE;
      end
      R_WAIT: if (ertn_flush) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lie_q    <= '0;
      is_sw_q  <= '0;
      is_hw_q  <= '0;
      ti_q     <= 1'b0;
      tcfg_q   <= '0;
      tval_q   <= '1;
      tstate_q <= T_OFF;
      rstate_q <= R_IDLE;
    end else begin
      lie_q    <= lie_d;
      is_sw_q  <= is_sw_d;
      is_hw_q  <= is_hw_d;
      ti_q     <= ti_d;
      tcfg_q   <= tcfg_d;
      tval_q   <= tval_d;
      tstate_q <= tstate_d;
      rstate_q <= rstate_d;
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_ECFG:  csr_rdata = 32'(lie_q);
      ADDR_ESTAT: csr_rdata = 32'(is_vec);
      ADDR_TCFG:  csr_rdata = 32'(tcfg_q);
      ADDR_TVAL:  csr_rdata = 32'(tval_q);
      default:    csr_rdata = '0;
    endcase
  end

  assign int_req           = (rstate_q == R_REQ);
  assign csr_ecfg_lie_soft = lie_q[1:0];
  assign timer_int         = ti_q;

endmodule

// File: tb/tb_csr_int_unit.sv
// Scoreboard bench for csr_int_unit: directed stimulus pushes expectations, a negedge monitor compares.
module tb_csr_int_unit;
  localparam int K_RD = 0, K_REQ = 1, K_TI = 2, K_LIE = 3;
  localparam logic [13:0] A_ECFG = 14'h004, A_ESTAT = 14'h005, A_TCFG = 14'h041,
                          A_TVAL = 14'h042, A_TICLR = 14'h044, A_NONE = 14'h006;
`ifdef IPI_EN
  localparam logic [31:0] LIE_ALL = 32'h0000_1BFF;
`else
  localparam logic [31:0] LIE_ALL = 32'h0000_0BFF;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_we = 1'b0;
  logic [13:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_wmask = '0;
  logic [31:0] csr_rdata;
  logic [7:0]  hw_int_in = '0;
  logic        crmd_ie = 1'b0;
  logic        int_ack = 1'b0;
  logic        ertn_flush = 1'b0;
  logic        int_req;
  logic [1:0]  csr_ecfg_lie_soft;
  logic        timer_int;
`ifdef IPI_EN
  logic        ipi_int_in = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;
  item_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  csr_int_unit #(.TIMER_W(32)) dut (
    .clk(clk), .reset(reset), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_wmask(csr_wmask), .csr_rdata(csr_rdata),
    .hw_int_in(hw_int_in),
`ifdef IPI_EN
    .ipi_int_in(ipi_int_in),
`endif
    .crmd_ie(crmd_ie), .int_ack(int_ack), .ertn_flush(ertn_flush),
    .int_req(int_req), .csr_ecfg_lie_soft(csr_ecfg_lie_soft), .timer_int(timer_int)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
    csr_addr = a; csr_wdata = d; csr_wmask = m; csr_we = 1'b1;
    tick(1);
    csr_we = 1'b0;
  endtask

  task automatic chk(input int k, input logic [31:0] e, input string n);
    item_t it;
    it.kind = k; it.exp = e; it.name = n;
    sb.push_back(it);
  endtask

  // Read checks hold csr_addr until the monitor has sampled this cycle
  task automatic chk_rd(input logic [13:0] a, input logic [31:0] e, input string n);
    csr_addr = a;
    chk(K_RD, e, n);
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    item_t       it;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.kind)
          K_RD:    act = csr_rdata;
          K_REQ:   act = {31'b0, int_req};
          K_TI:    act = {31'b0, timer_int};
          default: act = {30'b0, csr_ecfg_lie_soft};
        endcase
        vectors++;
        if (act !== it.exp) begin
          miscompares++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // reset state
    tick(2);
    chk(K_REQ, 0, "rst_req"); chk(K_TI, 0, "rst_ti"); chk(K_LIE, 0, "rst_lie_soft");
    chk_rd(A_TVAL, 32'hFFFF_FFFF, "rst_tval");
    tick(1); chk_rd(A_ECFG, 0, "rst_ecfg");
    tick(1); chk_rd(A_ESTAT, 0, "rst_estat");
    tick(1); chk_rd(A_TCFG, 0, "rst_tcfg");
    reset = 1'b0;
    tick(1);

    // one-shot timer, InitVal=5
    wr(A_TCFG, 32'h15, 32'hFFFF_FFFF);
    chk_rd(A_TVAL, 32'h14, "os_load");
    tick(1);  chk_rd(A_TVAL, 32'h13, "os_dec");
    tick(19); chk(K_TI, 0, "os_ti_before"); chk_rd(A_TVAL, 0, "os_tval_zero");
    tick(1);  chk(K_TI, 1, "os_ti_set"); chk_rd(A_TVAL, 0, "os_tval_done");
    tick(5);  chk_rd(A_TVAL, 0, "os_tval_hold");
    tick(1);  chk_rd(A_ESTAT, 32'h800, "os_estat_ti");
    tick(1);  chk_rd(A_TCFG, 32'h15, "os_tcfg_rd");
    wr(A_TICLR, 32'h1, 32'h0); chk(K_TI, 1, "ticlr_masked");
    wr(A_TICLR, 32'h1, 32'h1); chk(K_TI, 0, "ticlr_clear");
    chk_rd(A_TICLR, 0, "ticlr_rd");
    tick(4);  chk(K_TI, 0, "os_no_second_ti");

    // periodic timer, InitVal=2 (reload 8)
    wr(A_TCFG, 32'hB, 32'hFFFF_FFFF);
    chk_rd(A_TVAL, 32'h8, "per_load");
    tick(8); chk(K_TI, 0, "per_ti_before"); chk_rd(A_TVAL, 0, "per_zero");
    tick(1); chk(K_TI, 1, "per_ti_set"); chk_rd(A_TVAL, 32'h8, "per_reload");
    wr(A_TICLR, 32'h1, 32'h1); chk(K_TI, 0, "per_clear"); chk_rd(A_TVAL, 32'h7, "per_dec");
    tick(7); chk(K_TI, 0, "per_ti_before2"); chk_rd(A_TVAL, 0, "per_zero2");
    wr(A_TICLR, 32'h1, 32'h1); chk(K_TI, 1, "per_set_beats_clear");
    chk_rd(A_TVAL, 32'h8, "per_reload2");
    wr(A_TCFG, 32'h0, 32'hFFFF_FFFF); chk_rd(A_TVAL, 32'h8, "off_hold");
    tick(3); chk_rd(A_TVAL, 32'h8, "off_hold2");
    wr(A_TICLR, 32'h1, 32'h1); chk(K_TI, 0, "off_clear");

    // InitVal=0 and TCFG write colliding with expiry
    wr(A_TCFG, 32'h3, 32'hFFFF_FFFF); chk_rd(A_TVAL, 0, "iv0_load");
    wr(A_TCFG, 32'h0, 32'hFFFF_FFFF); chk(K_TI, 0, "wr_beats_expiry");
    tick(1); chk(K_TI, 0, "wr_beats_expiry2");
    wr(A_TCFG, 32'h3, 32'hFFFF_FFFF); chk(K_TI, 0, "iv0_after_load");
    tick(1); chk(K_TI, 1, "iv0_expire"); chk_rd(A_TVAL, 0, "iv0_reload");
    wr(A_TICLR, 32'h1, 32'h1); chk(K_TI, 1, "iv0_every_cycle");
    wr(A_TCFG, 32'h0, 32'hFFFF_FFFF); chk(K_TI, 1, "iv0_disable");
    wr(A_TICLR, 32'h1, 32'h1); chk(K_TI, 0, "iv0_clear");

    // write masks, read-only bits, unmapped address
    wr(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk(K_LIE, 3, "lie_soft_all"); chk_rd(A_ECFG, LIE_ALL, "ecfg_ro_bits");
    wr(A_ECFG, 32'h0, 32'h3); chk(K_LIE, 0, "lie_soft_clr");
    chk_rd(A_ECFG, LIE_ALL & 32'hFFFF_FFFC, "ecfg_masked");
    wr(A_ECFG, 32'h0, 32'hFFFF_FFFF);
    wr(A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF); chk_rd(A_ESTAT, 32'h3, "estat_sw_only");
    wr(A_ESTAT, 32'h0, 32'h3);
    wr(A_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF); chk_rd(A_NONE, 0, "unmapped_rd");

    // soft interrupt request / ack / ertn handshake
    wr(A_ECFG, 32'h2, 32'hFFFF_FFFF);
    crmd_ie = 1'b1;
    wr(A_ESTAT, 32'h2, 32'h3); chk(K_REQ, 0, "sw_req_latency"); chk_rd(A_ESTAT, 32'h2, "sw_is1");
    tick(1); chk(K_REQ, 1, "sw_req_rise");
    tick(2); chk(K_REQ, 1, "sw_req_hold");
    int_ack = 1'b1; tick(1); int_ack = 1'b0; chk(K_REQ, 0, "ack_drop");
    tick(3); chk(K_REQ, 0, "wait_hold");
    ertn_flush = 1'b1; tick(1); ertn_flush = 1'b0; chk(K_REQ, 0, "ertn_idle");
    tick(1); chk(K_REQ, 1, "ertn_rereq");
    int_ack = 1'b1; crmd_ie = 1'b0; tick(1); int_ack = 1'b0; chk(K_REQ, 0, "ack_beats_drop");
    crmd_ie = 1'b1; tick(2); chk(K_REQ, 0, "ack_went_wait");
    crmd_ie = 1'b0; ertn_flush = 1'b1; tick(1); chk(K_REQ, 0, "wait_to_idle");
    tick(1); ertn_flush = 1'b0; chk(K_REQ, 0, "ertn_in_idle");
    crmd_ie = 1'b1; tick(1); chk(K_REQ, 1, "idle_to_req");
    ertn_flush = 1'b1; tick(1); ertn_flush = 1'b0; chk(K_REQ, 1, "ertn_in_req");
    crmd_ie = 1'b0; tick(1);
    wr(A_ESTAT, 32'h0, 32'h3); chk(K_REQ, 0, "sw_cleanup");

    // hardware line with crmd_ie dropping before ack
    wr(A_ECFG, 32'h20, 32'hFFFF_FFFF);
    hw_int_in = 8'h08; crmd_ie = 1'b1;
    tick(1); chk(K_REQ, 0, "hw_latency"); chk_rd(A_ESTAT, 32'h20, "hw_is5");
    tick(1); chk(K_REQ, 1, "hw_req");
    crmd_ie = 1'b0; tick(1); chk(K_REQ, 0, "hw_ie_drop");
    tick(1); chk(K_REQ, 0, "hw_idle");
    crmd_ie = 1'b1; tick(1); chk(K_REQ, 1, "hw_rereq");

    // reset while requesting with the timer running
    wr(A_TCFG, 32'h15, 32'hFFFF_FFFF);
    tick(2); chk(K_REQ, 1, "pre_rst_req"); chk_rd(A_TVAL, 32'h12, "pre_rst_tval");
    reset = 1'b1;
    tick(1); chk(K_REQ, 0, "mid_rst_req"); chk(K_TI, 0, "mid_rst_ti"); chk(K_LIE, 0, "mid_rst_lie");
    chk_rd(A_TVAL, 32'hFFFF_FFFF, "mid_rst_tval");
    tick(1); chk_rd(A_ECFG, 0, "mid_rst_ecfg");
    tick(1); chk_rd(A_ESTAT, 0, "mid_rst_estat");
    tick(1); chk_rd(A_TCFG, 0, "mid_rst_tcfg");
    hw_int_in = 8'h00; crmd_ie = 1'b0; reset = 1'b0;
    tick(1); chk(K_REQ, 0, "post_rst_req"); chk_rd(A_TVAL, 32'hFFFF_FFFF, "post_rst_tval");

    // IS[12] / LIE[12]
`ifdef IPI_EN
    ipi_int_in = 1'b1; crmd_ie = 1'b1;
    tick(1);
    wr(A_ECFG, 32'h1000, 32'hFFFF_FFFF); chk(K_REQ, 0, "ipi_latency");
    chk_rd(A_ECFG, 32'h1000, "ipi_lie12");
    tick(1); chk(K_REQ, 1, "ipi_req");
`else
    wr(A_ECFG, 32'h1000, 32'hFFFF_FFFF); chk_rd(A_ECFG, 0, "no_ipi_lie12");
    wr(A_ESTAT, 32'h1000, 32'h1000); chk_rd(A_ESTAT, 0, "no_ipi_is12");
`endif

    tick(2);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d items left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
